// File: rtl/layer_seq_pkg.sv
// layer_seq_pkg: shared types for the multi-layer run sequencer.
// Holds the FSM state enum, descriptor field indices and the per-layer
// descriptor record (eight config words).
package layer_seq_pkg;

  localparam int LS_WORD_W = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_KICK = 3'd2,
    S_WAIT = 3'd3,
    S_NEXT = 3'd4,
    S_DONE = 3'd5
  } state_e;

  localparam logic [2:0] F_OP_CONFIG   = 3'd0;
  localparam logic [2:0] F_MAPPING     = 3'd1;
  localparam logic [2:0] F_SHAPE1      = 3'd2;
  localparam logic [2:0] F_SHAPE2      = 3'd3;
  localparam logic [2:0] F_FILTER_BASE = 3'd4;
  localparam logic [2:0] F_IFMAP_BASE  = 3'd5;
  localparam logic [2:0] F_BIAS_BASE   = 3'd6;
  localparam logic [2:0] F_OPSUM_BASE  = 3'd7;

  typedef struct packed {
    logic [LS_WORD_W-1:0] op_config;
    logic [LS_WORD_W-1:0] mapping_param;
    logic [LS_WORD_W-1:0] shape_param1;
    logic [LS_WORD_W-1:0] shape_param2;
    logic [LS_WORD_W-1:0] filter_base;
    logic [LS_WORD_W-1:0] ifmap_base;
    logic [LS_WORD_W-1:0] bias_base;
    logic [LS_WORD_W-1:0] opsum_base;
  } layer_desc_t;

endpackage

// File: rtl/layer_desc_table.sv
// layer_desc_table: per-layer descriptor register file.
// Ports: clk; we_i/wr_idx_i/wr_field_i/wr_data_i one word write port;
//        rd_idx_i -> rd_desc_o combinational full-descriptor read port.
// Contents are deliberately not reset; the host programs entries before a run.
module layer_desc_table
  import layer_seq_pkg::*;
#(
  parameter int NUM_LAYERS = 8,
  parameter int IDX_W      = $clog2(NUM_LAYERS)
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [IDX_W-1:0]     wr_idx_i,
  input  logic [2:0]           wr_field_i,
  input  logic [LS_WORD_W-1:0] wr_data_i,
  input  logic [IDX_W-1:0]     rd_idx_i,
  output layer_desc_t          rd_desc_o
);

  layer_desc_t table_q [NUM_LAYERS];

  // Out-of-range indices (non power-of-two depth) are dropped.
  always_ff @(posedge clk) begin
    if (we_i && (int'(wr_idx_i) < NUM_LAYERS)) begin
      case (wr_field_i)
        F_OP_CONFIG:   table_q[wr_idx_i].op_config     <= wr_data_i;
        F_MAPPING:     table_q[wr_idx_i].mapping_param <= wr_data_i;
        F_SHAPE1:      table_q[wr_idx_i].shape_param1  <= wr_data_i;
        F_SHAPE2:      table_q[wr_idx_i].shape_param2  <= wr_data_i;
        F_FILTER_BASE: table_q[wr_idx_i].filter_base   <= wr_data_i;
        F_IFMAP_BASE:  table_q[wr_idx_i].ifmap_base    <= wr_data_i;
        F_BIAS_BASE:   table_q[wr_idx_i].bias_base     <= wr_data_i;
        default:       table_q[wr_idx_i].opsum_base    <= wr_data_i;
      endcase
    end
  end

  assign rd_desc_o = table_q[rd_idx_i];

endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: walks a descriptor table, issuing one controller_pass run per layer.
// Ports: clk/rst (sync, active-high); start/layer_count run request; done/busy/cur_layer
//        status; cfg_* descriptor write port; registered config words, pass_start/pass_done
//        handshake to controller_pass. Start->first pass_start 2 cycles, 3 cycles between layers.
// Optional macro LAYER_SEQ_CHAIN_ADDR_EN: layer idx>0 takes ifmap base from layer idx-1 opsum base.
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int NUM_LAYERS = 8,
  parameter int WORD_W     = LS_WORD_W,
  parameter int IDX_W      = $clog2(NUM_LAYERS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W:0]    layer_count,
  output logic              done,
  output logic              busy,
  output logic [IDX_W-1:0]  cur_layer,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_layer,
  input  logic [2:0]        cfg_field,
  input  logic [WORD_W-1:0] cfg_wdata,
  output logic              bias_ipsum_sel,
  output logic [WORD_W-1:0] op_config,
  output logic [WORD_W-1:0] mapping_param,
  output logic [WORD_W-1:0] shape_param1,
  output logic [WORD_W-1:0] shape_param2,
  output logic [WORD_W-1:0] filter_baseaddr,
  output logic [WORD_W-1:0] ifmap_baseaddr,
  output logic [WORD_W-1:0] bias_baseaddr,
  output logic [WORD_W-1:0] opsum_baseaddr,
  output logic              pass_start,
  input  logic              pass_done
);

  localparam logic [IDX_W:0] CNT_MAX = (IDX_W+1)'(NUM_LAYERS);
  localparam logic [IDX_W:0] CNT_ONE = (IDX_W+1)'(1);

  state_e           state_q, state_d;
  // idx/n carry one extra bit so a full power-of-two table does not wrap.
  logic [IDX_W:0]   idx_q, idx_d;
  logic [IDX_W:0]   n_q, n_d;
  logic [IDX_W-1:0] cur_layer_q;
  layer_desc_t      cfg_q;
  layer_desc_t      rd_desc;
  layer_desc_t      load_desc;
  logic             load_en;
  logic [IDX_W:0]   cnt_clamped;

  layer_desc_table #(
    .NUM_LAYERS (NUM_LAYERS),
    .IDX_W      (IDX_W)
  ) u_table (
    .clk        (clk),
    .we_i       (cfg_we && !busy),
    .wr_idx_i   (cfg_layer),
    .wr_field_i (cfg_field),
    .wr_data_i  (cfg_wdata),
    .rd_idx_i   (idx_q[IDX_W-1:0]),
    .rd_desc_o  (rd_desc)
  );

  assign cnt_clamped = (layer_count > CNT_MAX) ? CNT_MAX : layer_count;

  // cfg_q still holds the previous layer during LOAD, so its opsum base
  // is exactly the chained ifmap base for the layer being loaded.
  always_comb begin
    load_desc = rd_desc;
`ifdef LAYER_SEQ_CHAIN_ADDR_EN
    if (idx_q != '0) begin
      load_desc.ifmap_base = cfg_q.opsum_base;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    load_en = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          n_d     = cnt_clamped;
          idx_d   = '0;
          state_d = (cnt_clamped == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        load_en = 1'b1;
        state_d = S_KICK;
      end
      S_KICK: state_d = S_WAIT;
      S_WAIT: begin
        if (pass_done) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (idx_q == n_q - CNT_ONE) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + CNT_ONE;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      n_q         <= '0;
      cur_layer_q <= '0;
      cfg_q       <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      if (load_en) begin
        cfg_q       <= load_desc;
        cur_layer_q <= idx_q[IDX_W-1:0];
      end
    end
  end

  assign done            = (state_q == S_DONE);
  assign busy            = (state_q != S_IDLE) && (state_q != S_DONE);
  // Gated by rst so a reset landing on KICK never issues a pass.
  assign pass_start      = (state_q == S_KICK) && !rst;
  assign cur_layer       = cur_layer_q;
  assign op_config       = cfg_q.op_config;
  assign bias_ipsum_sel  = cfg_q.op_config[LS_WORD_W-1];
  assign mapping_param   = cfg_q.mapping_param;
  assign shape_param1    = cfg_q.shape_param1;
  assign shape_param2    = cfg_q.shape_param2;
  assign filter_baseaddr = cfg_q.filter_base;
  assign ifmap_baseaddr  = cfg_q.ifmap_base;
  assign bias_baseaddr   = cfg_q.bias_base;
  assign opsum_baseaddr  = cfg_q.opsum_base;

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed self-checking bench for layer_sequencer.
// Expected per-layer config is pushed to a scoreboard at start and popped on each pass_start.
module tb_layer_sequencer;
  import layer_seq_pkg::*;

  localparam int NL = 8;
  localparam int IW = 3;
  localparam int W  = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [IW:0]   layer_count = '0;
  logic          done, busy, pass_start;
  logic [IW-1:0] cur_layer;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_layer = '0;
  logic [2:0]    cfg_field = '0;
  logic [W-1:0]  cfg_wdata = '0;
  logic          bias_ipsum_sel;
  logic [W-1:0]  op_config, mapping_param, shape_param1, shape_param2;
  logic [W-1:0]  filter_baseaddr, ifmap_baseaddr, bias_baseaddr, opsum_baseaddr;
  logic          pass_done = 1'b0;

  layer_sequencer #(.NUM_LAYERS(NL), .WORD_W(W), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .layer_count(layer_count),
    .done(done), .busy(busy), .cur_layer(cur_layer),
    .cfg_we(cfg_we), .cfg_layer(cfg_layer), .cfg_field(cfg_field), .cfg_wdata(cfg_wdata),
    .bias_ipsum_sel(bias_ipsum_sel), .op_config(op_config), .mapping_param(mapping_param),
    .shape_param1(shape_param1), .shape_param2(shape_param2),
    .filter_baseaddr(filter_baseaddr), .ifmap_baseaddr(ifmap_baseaddr),
    .bias_baseaddr(bias_baseaddr), .opsum_baseaddr(opsum_baseaddr),
    .pass_start(pass_start), .pass_done(pass_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int errors   = 0;
  int kick_cnt = 0;

  always @(posedge clk) if (pass_start === 1'b1) kick_cnt <= kick_cnt + 1;

  logic [W-1:0] shadow [NL][8];
  logic [W-1:0] seen_ifmap [NL];
  layer_desc_t  exp_q [$];
  int           exp_layer_q [$];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wr(input int l, input int f, input logic [W-1:0] d, input bit track);
    cfg_we    = 1'b1;
    cfg_layer = l[IW-1:0];
    cfg_field = f[2:0];
    cfg_wdata = d;
    cyc();
    cfg_we = 1'b0;
    if (track) shadow[l][f] = d;
  endtask

  task automatic wr_layer(input int l, input logic [W-1:0] base);
    for (int f = 0; f < 8; f++) wr(l, f, base + W'(f), 1'b1);
  endtask

  function automatic layer_desc_t model(input int i);
    layer_desc_t d;
    d.op_config     = shadow[i][0];
    d.mapping_param = shadow[i][1];
    d.shape_param1  = shadow[i][2];
    d.shape_param2  = shadow[i][3];
    d.filter_base   = shadow[i][4];
    d.ifmap_base    = shadow[i][5];
    d.bias_base     = shadow[i][6];
    d.opsum_base    = shadow[i][7];
`ifdef LAYER_SEQ_CHAIN_ADDR_EN
    if (i > 0) d.ifmap_base = shadow[i-1][7];
`endif
    return d;
  endfunction

  task automatic cmp_outs(input string tag, input layer_desc_t e, input int l);
    chk({tag, ".cur_layer"}, W'(cur_layer), W'(l));
    chk({tag, ".op_config"}, op_config, e.op_config);
    chk({tag, ".bias_sel"}, W'(bias_ipsum_sel), W'(e.op_config[W-1]));
    chk({tag, ".mapping"}, mapping_param, e.mapping_param);
    chk({tag, ".shape1"}, shape_param1, e.shape_param1);
    chk({tag, ".shape2"}, shape_param2, e.shape_param2);
    chk({tag, ".filter"}, filter_baseaddr, e.filter_base);
    chk({tag, ".ifmap"}, ifmap_baseaddr, e.ifmap_base);
    chk({tag, ".bias"}, bias_baseaddr, e.bias_base);
    chk({tag, ".opsum"}, opsum_baseaddr, e.opsum_base);
  endtask

  task automatic wait_kick(output int w);
    w = 0;
    while (pass_start !== 1'b1 && w < 20) begin
      cyc();
      w++;
    end
    chk("kick_timeout", W'(w < 20), W'(1));
  endtask

  task automatic run(input int cnt, input int dly);
    int n, k0, w, l;
    layer_desc_t e;
    n  = (cnt > NL) ? NL : cnt;
    k0 = kick_cnt;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model(i));
      exp_layer_q.push_back(i);
    end
    start       = 1'b1;
    layer_count = cnt[IW:0];
    cyc();
    start = 1'b0;
    if (n == 0) begin
      chk("zero.done", W'(done), W'(1));
      chk("zero.busy", W'(busy), W'(0));
      cyc(); cyc();
      chk("zero.kicks", W'(kick_cnt - k0), W'(0));
      chk("zero.done_hold", W'(done), W'(1));
      return;
    end
    chk("start.busy", W'(busy), W'(1));
    chk("start.done_drop", W'(done), W'(0));
    for (int i = 0; i < n; i++) begin
      wait_kick(w);
      chk("kick.gap", W'(w), (i == 0) ? W'(1) : W'(2));
      if (w >= 20) return;
      e = exp_q.pop_front();
      l = exp_layer_q.pop_front();
      cmp_outs("kick", e, l);
      seen_ifmap[l] = ifmap_baseaddr;
      cyc();
      chk("kick.width", W'(pass_start), W'(0));
      repeat (dly - 1) cyc();
      cmp_outs("hold", e, l);
      pass_done = 1'b1;
      cyc();
      pass_done = 1'b0;
    end
    chk("next.done", W'(done), W'(0));
    cyc();
    chk("run.done", W'(done), W'(1));
    chk("run.busy", W'(busy), W'(0));
    chk("run.kicks", W'(kick_cnt - k0), W'(n));
  endtask

  initial begin
    int w, k0;
    layer_desc_t zero_d, e0;
    zero_d = '0;

    // Reset state
    repeat (3) cyc();
    chk("rst.done", W'(done), W'(0));
    chk("rst.busy", W'(busy), W'(0));
    chk("rst.pass_start", W'(pass_start), W'(0));
    cmp_outs("rst", zero_d, 0);
    rst = 1'b0;
    cyc();

    // Single layer, pass_done 10 cycles after kick
    for (int f = 0; f < 8; f++) wr(0, f, 32'h0000_0100 + W'(f), 1'b1);
    wr(0, 0, 32'h0000_0409, 1'b1);
    wr(0, 7, 32'h0000_1000, 1'b1);
    run(1, 10);

    // Three distinct layers; layer 1 sets bias_ipsum_sel
    wr_layer(1, 32'hA000_0010);
    wr_layer(2, 32'h0B00_0020);
    run(3, 4);

    // Zero layers, then clamped over-count
    run(0, 1);
    for (int l = 3; l < NL; l++) wr_layer(l, W'(l) << 12);
    run(15, 1);

    // Write during WAIT is dropped; pass_done during KICK ignored
    e0 = model(0);
    k0 = kick_cnt;
    start = 1'b1; layer_count = 1;
    cyc();
    start = 1'b0;
    wait_kick(w);
    pass_done = 1'b1;
    cyc();
    pass_done = 1'b0;
    chk("kickdone.busy", W'(busy), W'(1));
    chk("kickdone.done", W'(done), W'(0));
    wr(0, 0, 32'hDEAD_BEEF, 1'b0);
    cyc(); cyc();
    chk("wait.busy", W'(busy), W'(1));
    chk("wait.kicks", W'(kick_cnt - k0), W'(1));
    cmp_outs("wait_wr", e0, 0);
    pass_done = 1'b1;
    cyc();
    pass_done = 1'b0;
    cyc();
    chk("wait.done", W'(done), W'(1));
    run(1, 2);

    // Reset during WAIT of layer 1
    start = 1'b1; layer_count = 2;
    cyc();
    start = 1'b0;
    wait_kick(w);
    cyc();
    pass_done = 1'b1;
    cyc();
    pass_done = 1'b0;
    wait_kick(w);
    chk("mid.cur_layer", W'(cur_layer), W'(1));
    cyc(); cyc();
    rst = 1'b1;
    chk("mid.rst_cycle_kick", W'(pass_start), W'(0));
    cyc();
    chk("mid.done", W'(done), W'(0));
    chk("mid.busy", W'(busy), W'(0));
    chk("mid.kick", W'(pass_start), W'(0));
    cmp_outs("mid", zero_d, 0);
    rst = 1'b0;
    cyc();
    run(2, 3);

    // Address chaining: layer 1 ifmap vs layer 0 opsum
    wr(0, 7, 32'h0000_2000, 1'b1);
    wr(1, 5, 32'h0000_9999, 1'b1);
    run(2, 2);
`ifdef LAYER_SEQ_CHAIN_ADDR_EN
    chk("chain.ifmap1", seen_ifmap[1], 32'h0000_2000);
`else
    chk("chain.ifmap1", seen_ifmap[1], 32'h0000_9999);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
